// File: rtl/pe_ctrl.sv
// Sequencer for a 3-weight PE: clears it, loads weights, streams activation pairs,
// drains the pipeline. Define PE_CTRL_PERF_EN to include the busy-cycle counter.
//
// state  | meaning
// IDLE   | waiting for start
// CLR    | one cycle PE clear
// LOAD_W | capturing three weight words
// RUN    | forwarding activation pairs
// DRAIN  | four cycles to flush the PE pipeline
// ABORT  | input gap seen, one cycle PE clear
// DONE   | one cycle completion pulse
module pe_ctrl #(
    parameter int N     = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [N-1:0]     w_data,
    input  logic             w_valid,
    input  logic [N-1:0]     in_data0,
    input  logic [N-1:0]     in_data1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     pe_i0,
    output logic [N-1:0]     pe_i1,
    output logic [N-1:0]     pe_w0,
    output logic [N-1:0]     pe_w1,
    output logic [N-1:0]     pe_w2,
    output logic [3:0]       pe_sel_m,
    output logic [1:0]       pe_sel_o,
    output logic             pe_rst_n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      perf_cycles
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        LOAD_W = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4,
        ABORT  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       widx_q, widx_d;
    logic [1:0]       drain_q, drain_d;
    logic             err_q, err_d;
    logic [N-1:0]     w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    logic [N-1:0]     i0_q, i0_d, i1_q, i1_d;
    logic [3:0]       sel_m_q, sel_m_d;
    logic [1:0]       sel_o_q, sel_o_d;
    logic             rst_n_q, rst_n_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic             sel_on;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        drain_d = drain_q;
        err_d   = err_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    len_d   = cfg_len;
                    cnt_d   = '0;
                    widx_d  = 2'd0;
                    err_d   = 1'b0;
                    state_d = (cfg_len != '0) ? CLR : DONE;
                end
            end
            CLR: state_d = LOAD_W;
            LOAD_W: begin
                if (w_valid) begin
                    case (widx_q)
                        2'd0:    w0_d = w_data;
                        2'd1:    w1_d = w_data;
                        default: w2_d = w_data;
                    endcase
                    widx_d = widx_q + 2'd1;
                    if (widx_q == 2'd2) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        state_d = DRAIN;
                        drain_d = 2'd3;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = ABORT;
                end
            end
            DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            ABORT:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Selects follow the first forwarded pair, so they rise together with pe_i*.
        sel_on  = accept || (state_d == DRAIN);
        sel_m_d = (sel_on && !mode_q) ? 4'b1111 : 4'b0000;
        sel_o_d = (sel_on && !mode_q) ? 2'b10 : 2'b00;
        i0_d    = accept ? in_data0 : '0;
        i1_d    = accept ? in_data1 : '0;
        ready_d = (state_d == RUN);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        rst_n_d = !((state_d == CLR) || (state_d == ABORT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            widx_q  <= 2'd0;
            drain_q <= 2'd0;
            err_q   <= 1'b0;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            i0_q    <= '0;
            i1_q    <= '0;
            sel_m_q <= 4'b0000;
            sel_o_q <= 2'b00;
            rst_n_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            i0_q    <= i0_d;
            i1_q    <= i1_d;
            sel_m_q <= sel_m_d;
            sel_o_q <= sel_o_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef PE_CTRL_PERF_EN
    logic [15:0] perf_q, perf_d;

    // The DONE cycle is not counted, so the value is final while done is high.
    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE) begin
            if (start) begin
                perf_d = 16'd0;
            end
        end else if ((state_q != DONE) && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= 16'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 16'd0;
`endif

    assign in_ready = ready_q;
    assign pe_i0    = i0_q;
    assign pe_i1    = i1_q;
    assign pe_w0    = w0_q;
    assign pe_w1    = w1_q;
    assign pe_w2    = w2_q;
    assign pe_sel_m = sel_m_q;
    assign pe_sel_o = sel_o_q;
    assign pe_rst_n = rst_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pe_ctrl.sv
// Bench for pe_ctrl: directed job table, reset-in-DRAIN sequence and random jobs,
// each checked against a job-level model computed from the stimulus arrays.
module tb_pe_ctrl;

    localparam int AW = 320;

    logic        clk = 1'b0;
    logic        reset, start, mode;
    logic [7:0]  cfg_len, w_data, in_data0, in_data1;
    logic        w_valid, in_valid, in_ready;
    logic [7:0]  pe_i0, pe_i1, pe_w0, pe_w1, pe_w2;
    logic [3:0]  pe_sel_m;
    logic [1:0]  pe_sel_o;
    logic        pe_rst_n, busy, done, err;
    logic [15:0] perf_cycles;

    pe_ctrl #(.N(8), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .cfg_len(cfg_len),
        .w_data(w_data), .w_valid(w_valid), .in_data0(in_data0), .in_data1(in_data1),
        .in_valid(in_valid), .in_ready(in_ready), .pe_i0(pe_i0), .pe_i1(pe_i1),
        .pe_w0(pe_w0), .pe_w1(pe_w1), .pe_w2(pe_w2), .pe_sel_m(pe_sel_m),
        .pe_sel_o(pe_sel_o), .pe_rst_n(pe_rst_n), .busy(busy), .done(done), .err(err),
        .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus per edge: index e = inputs sampled at edge e, start at edge 0.
    bit         wv_a[AW];
    bit         iv_a[AW];
    logic [7:0] wd_a[AW];
    logic [7:0] d0_a[AW];
    logic [7:0] d1_a[AW];
    int         poke_e;
    logic [7:0] exp_w[3];

    typedef struct {
        bit mode;
        int len;
        int wgap;
        int gap_j;
        int exp_d;
        int exp_err;
        int exp_pairs;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_edge(input int i);
        if (i < AW) begin
            w_valid = wv_a[i]; w_data = wd_a[i];
            in_valid = iv_a[i]; in_data0 = d0_a[i]; in_data1 = d1_a[i];
        end else begin
            w_valid = 1'b1; w_data = 8'($urandom);
            in_valid = 1'b1; in_data0 = 8'($urandom_range(255, 1)); in_data1 = 8'($urandom);
        end
        start   = (i == poke_e);
        cfg_len = 8'($urandom_range(255, 1));
        mode    = 1'($urandom);
    endtask

    task automatic fill_directed(input int wgap, input int gap_j);
        int e3;
        e3 = 2 + 2 * (wgap + 1);
        for (int e = 0; e < AW; e++) begin
            wv_a[e] = (e >= 2) && (((e - 2) % (wgap + 1)) == 0);
            iv_a[e] = !((gap_j >= 0) && (e == e3 + 1 + gap_j));
            wd_a[e] = 8'($urandom);
            d0_a[e] = 8'($urandom_range(255, 1));
            d1_a[e] = 8'($urandom);
        end
    endtask

    task automatic fill_random();
        for (int e = 0; e < AW; e++) begin
            wv_a[e] = (e >= 40) ? 1'b1 : 1'($urandom);
            iv_a[e] = ($urandom_range(15, 0) != 0);
            wd_a[e] = 8'($urandom);
            d0_a[e] = 8'($urandom_range(255, 1));
            d1_a[e] = 8'($urandom);
        end
    endtask

    task automatic run_job(input bit m, input int len, output int d_obs,
                           output int err_obs, output int pairs_obs);
        int e3, nw, acc, d, first_done, done_cnt, busy_cnt, rstn_lo, rdy_cnt;
        int sel_on, sel_bad, exp_sel, exp_rdy, exp_rstn;
        bit gap;
        logic [15:0] exp_q[$];
        logic [15:0] obs_q[$];
        logic [7:0] nw_w[3];
        nw_w = exp_w;
        gap = 1'b0; acc = 0; e3 = 0; nw = 0;
        if (len == 0) begin
            d = 1;
        end else begin
            for (int e = 2; e < AW; e++) begin
                if (wv_a[e] && nw < 3) begin
                    nw_w[nw] = wd_a[e];
                    nw++;
                    if (nw == 3) e3 = e;
                end
            end
            for (int j = 0; j < len; j++) begin
                if (!iv_a[e3 + 1 + j]) begin
                    gap = 1'b1;
                    break;
                end
                exp_q.push_back({d0_a[e3 + 1 + j], d1_a[e3 + 1 + j]});
                acc++;
            end
            d = gap ? e3 + acc + 3 : e3 + len + 5;
        end
        exp_sel  = (m || len == 0) ? 0 : (gap ? acc : acc + 3);
        exp_rdy  = (len == 0) ? 0 : (gap ? acc + 1 : len);
        exp_rstn = (len == 0) ? 0 : (gap ? 2 : 1);
        poke_e   = $urandom_range(d, 1);

        @(negedge clk);
        drive_edge(0);
        start = 1'b1; mode = m; cfg_len = len[7:0];
        first_done = -1; done_cnt = 0; busy_cnt = 0; rstn_lo = 0; rdy_cnt = 0;
        sel_on = 0; sel_bad = 0;
        for (int i = 1; i <= d + 20; i++) begin
            @(negedge clk);
            if (done) begin
                if (first_done < 0) first_done = i;
                done_cnt++;
            end
            busy_cnt += int'(busy);
            rstn_lo  += int'(!pe_rst_n);
            rdy_cnt  += int'(in_ready);
            if (pe_i0 != 0 || pe_i1 != 0) obs_q.push_back({pe_i0, pe_i1});
            if (pe_sel_m != 0 || pe_sel_o != 0) begin
                sel_on++;
                if (m || pe_sel_m != 4'b1111 || pe_sel_o != 2'b10) sel_bad++;
            end
            drive_edge(i);
            if (first_done >= 0 && i >= first_done + 3) break;
        end
        start = 1'b0;

        chk("done_cycle", first_done, d);
        chk("done_pulses", done_cnt, 1);
        chk("busy_cycles", busy_cnt, d);
        chk("pe_rst_n_low_cycles", rstn_lo, exp_rstn);
        chk("in_ready_cycles", rdy_cnt, exp_rdy);
        chk("select_cycles", sel_on, exp_sel);
        chk("select_pattern_bad", sel_bad, 0);
        chk("err", err, gap);
        chk("busy_idle", busy, 0);
        chk("pe_w0", pe_w0, nw_w[0]);
        chk("pe_w1", pe_w1, nw_w[1]);
        chk("pe_w2", pe_w2, nw_w[2]);
`ifdef PE_CTRL_PERF_EN
        chk("perf_cycles", perf_cycles, d - 1);
`else
        chk("perf_cycles", perf_cycles, 0);
`endif
        chk("pair_count", obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            chk("pair_data", obs_q[k], exp_q[k]);
        exp_w     = nw_w;
        d_obs     = first_done;
        err_obs   = int'(err);
        pairs_obs = obs_q.size();
    endtask

    initial begin
        int d_obs, e_obs, p_obs, dcnt;
        // mode, len, wgap, gap_j, expected done cycle, err, pairs
        tbl[0] = '{1'b0, 8,   0, -1, 17,  0, 8};
        tbl[1] = '{1'b1, 1,   0, -1, 10,  0, 1};
        tbl[2] = '{1'b0, 5,   0,  2, 9,   1, 2};
        tbl[3] = '{1'b1, 0,   0, -1, 1,   0, 0};
        tbl[4] = '{1'b0, 4,   2, -1, 17,  0, 4};
        tbl[5] = '{1'b0, 3,   0,  0, 7,   1, 0};
        tbl[6] = '{1'b1, 255, 1, -1, 266, 0, 255};
        tbl[7] = '{1'b0, 2,   0, -1, 11,  0, 2};

        reset = 1'b1; start = 1'b0; mode = 1'b0; cfg_len = 8'd0; w_data = 8'd0;
        w_valid = 1'b0; in_valid = 1'b0; in_data0 = 8'd0; in_data1 = 8'd0;
        poke_e = -1;
        exp_w = '{8'd0, 8'd0, 8'd0};
        repeat (3) @(negedge clk);
        chk("reset_outputs_nonzero",
            |{pe_i0, pe_i1, pe_w0, pe_w1, pe_w2, pe_sel_m, pe_sel_o, pe_rst_n,
              busy, done, err, in_ready, perf_cycles}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("pe_rst_n_after_reset", pe_rst_n, 1);
        chk("busy_after_reset", busy, 0);

        for (int t = 0; t < 8; t++) begin
            fill_directed(tbl[t].wgap, tbl[t].gap_j);
            run_job(tbl[t].mode, tbl[t].len, d_obs, e_obs, p_obs);
            chk("tbl_done_cycle", d_obs, tbl[t].exp_d);
            chk("tbl_err", e_obs, tbl[t].exp_err);
            chk("tbl_pairs", p_obs, tbl[t].exp_pairs);
        end

        // Reset pulsed in the second DRAIN cycle abandons the job.
        poke_e = -1;
        fill_directed(0, -1);
        @(negedge clk);
        drive_edge(0);
        start = 1'b1; mode = 1'b0; cfg_len = 8'd8;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            drive_edge(i);
        end
        @(negedge clk);
        chk("drain_busy", busy, 1);
        chk("drain_sel_m", pe_sel_m, 4'b1111);
        chk("drain_in_ready", in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("drain_reset_outputs_nonzero",
            |{pe_i0, pe_i1, pe_w0, pe_w1, pe_w2, pe_sel_m, pe_sel_o, pe_rst_n,
              busy, done, err, in_ready, perf_cycles}, 0);
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk("drain_reset_pe_rst_n", pe_rst_n, 1);
            dcnt += int'(done) + int'(busy);
        end
        chk("drain_reset_no_done_busy", dcnt, 0);
        exp_w = '{8'd0, 8'd0, 8'd0};
        fill_directed(0, -1);
        run_job(1'b0, 8, d_obs, e_obs, p_obs);
        chk("after_reset_done_cycle", d_obs, 17);

        for (int r = 0; r < 12; r++) begin
            fill_random();
            run_job(1'($urandom), (r % 5 == 4) ? 0 : $urandom_range(20, 1), d_obs, e_obs, p_obs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
